// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - memory arbiter for I-cache/D-cache block fills and D-cache stores
//
// Shares one pipelined, single-ported main memory between three requesters.
// A D-cache store is forwarded as a single write. A D-cache or I-cache block
// miss is fetched as a burst of word reads, and the returned words are
// streamed back to the cache that missed.
//
// Optional feature: define ARB_RR_EN to make d_miss vs i_miss arbitration
// round-robin. d_wr keeps absolute priority either way. Without the macro,
// d_miss always beats i_miss.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   i_miss, i_addr                     I-cache block miss request (level) and byte address
//   d_miss, d_addr                     D-cache block miss request (level) and byte address
//   d_wr, d_wr_addr, d_wr_data         D-cache store request (level), byte address, data
//   mem_en, mem_wr, mem_addr, mem_wdata  memory request strobe, direction, address, write data
//   mem_rdata, mem_rvalid              memory read return
//   fill_data, fill_idx                returned block word and its word index
//   fill_i_valid, fill_d_valid         fill_data is for the I-cache / D-cache
//   i_done, d_done                     1-cycle pulse: block fill complete
//   d_wr_ack                           1-cycle pulse: store issued to memory
//   busy                               arbiter not idle
module mem_arbiter #(
  parameter int MEM_LATENCY     = 4,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int IDX_W           = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_miss,
  input  logic [15:0]      i_addr,
  input  logic             d_miss,
  input  logic [15:0]      d_addr,
  input  logic             d_wr,
  input  logic [15:0]      d_wr_addr,
  input  logic [15:0]      d_wr_data,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_rvalid,
  output logic [15:0]      fill_data,
  output logic [IDX_W-1:0] fill_idx,
  output logic             fill_i_valid,
  output logic             fill_d_valid,
  output logic             i_done,
  output logic             d_done,
  output logic             d_wr_ack,
  output logic             busy
);

  // Block address is everything above the word index and the byte-in-word bit.
  localparam int BLK_W = 16 - IDX_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] issue_cnt_q;
  logic [IDX_W-1:0] recv_cnt_q;
  logic             owner_d_q;   // 1: current fill belongs to the D-cache
  logic [BLK_W-1:0] blk_q;

  logic             grant_miss;
  logic             grant_d;
  logic             recv_active;
  logic             beat;
  logic             last_beat;

  // Sub-block address bits and the memory latency are not needed here.
  logic unused_ok;
  assign unused_ok = ^{i_addr[IDX_W:0], d_addr[IDX_W:0], MEM_LATENCY[0]};

`ifdef ARB_RR_EN
  // 1: the last miss granted was the D-cache. Resets to I so D wins the first tie.
  logic last_d_q;
`endif

  // Receive path: only beats during an active fill count; rvalids seen in
  // IDLE, WRITE or DONE (including leftovers from an aborted fill) are dropped.
  assign recv_active = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign beat        = recv_active && mem_rvalid;
  assign last_beat   = beat && (recv_cnt_q == LAST_IDX);

  assign fill_data    = beat ? mem_rdata : '0;
  assign fill_idx     = beat ? recv_cnt_q : '0;
  assign fill_i_valid = beat && !owner_d_q;
  assign fill_d_valid = beat && owner_d_q;
  assign busy         = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    d_wr_ack   = 1'b0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    grant_miss = 1'b0;
    grant_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (d_wr) begin
          state_d = ST_WRITE;
        end else if (d_miss || i_miss) begin
          grant_miss = 1'b1;
`ifdef ARB_RR_EN
          grant_d    = d_miss && (!i_miss || !last_d_q);
`else
          grant_d    = d_miss;
`endif
          state_d    = ST_ISSUE;
        end
      end

      ST_WRITE: begin
        // Store request is held until acked, so its inputs are still valid here.
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        state_d   = ST_IDLE;
      end

      ST_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = {blk_q, issue_cnt_q, 1'b0};
        if (issue_cnt_q == LAST_IDX) begin
          // A zero-latency memory could return the final word on the last issue.
          state_d = last_beat ? ST_DONE : ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (last_beat) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        d_done  = owner_d_q;
        i_done  = !owner_d_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      owner_d_q   <= 1'b0;
      blk_q       <= '0;
    end else begin
      state_q <= state_d;

      if (grant_miss) begin
        owner_d_q <= grant_d;
        blk_q     <= grant_d ? d_addr[15:IDX_W+1] : i_addr[15:IDX_W+1];
      end

      // Both counters wrap to zero after the last word, ready for the next fill.
      if (state_q == ST_ISSUE) begin
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end else begin
        issue_cnt_q <= '0;
      end

      if (beat) begin
        recv_cnt_q <= recv_cnt_q + 1'b1;
      end else if (!recv_active) begin
        recv_cnt_q <= '0;
      end
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else if (grant_miss) begin
      last_d_q <= grant_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        i_miss, d_miss, d_wr;
  logic [15:0] i_addr, d_addr, d_wr_addr, d_wr_data;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic [15:0] fill_data;
  logic [2:0]  fill_idx;
  logic        fill_i_valid, fill_d_valid, i_done, d_done, d_wr_ack, busy;

  mem_arbiter #(.MEM_LATENCY(LAT), .WORDS_PER_BLOCK(8), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_addr(d_addr),
    .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .fill_i_valid(fill_i_valid), .fill_d_valid(fill_d_valid),
    .i_done(i_done), .d_done(d_done), .d_wr_ack(d_wr_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [58:0] all_outs;
  assign all_outs = {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx,
                     fill_i_valid, fill_d_valid, i_done, d_done, d_wr_ack, busy};

  // Memory model: fixed-latency read pipeline, optional random gaps between returns.
  int          cyc = 0;
  int          pend_rdy[$];
  logic [15:0] pend_dat[$];
  logic        mem_rv_q = 1'b0;
  logic [15:0] mem_rd_q = 16'h0;
  int          gap_cnt = 0;
  logic        gap_mode = 1'b0;
  logic [15:0] mem_base = 16'h0;
  logic        inj_rv = 1'b0;
  logic [15:0] inj_data = 16'h0;

  assign mem_rvalid = mem_rv_q | inj_rv;
  assign mem_rdata  = inj_rv ? inj_data : mem_rd_q;

  always @(posedge clk) begin
    if (mem_en && !mem_wr) begin
      pend_rdy.push_back(cyc + LAT);
      pend_dat.push_back(mem_base + {13'd0, mem_addr[3:1]});
    end
    if (gap_cnt != 0) begin
      gap_cnt  <= gap_cnt - 1;
      mem_rv_q <= 1'b0;
    end else if (pend_rdy.size() > 0 && pend_rdy[0] <= cyc + 1) begin
      mem_rv_q <= 1'b1;
      mem_rd_q <= pend_dat[0];
      void'(pend_rdy.pop_front());
      void'(pend_dat.pop_front());
      gap_cnt  <= gap_mode ? int'($urandom_range(0, 3)) : 0;
    end else begin
      mem_rv_q <= 1'b0;
    end
    cyc <= cyc + 1;
  end

  // Event logs, written only here.
  logic [15:0] iss_addr[$];
  logic        iss_wr[$];
  logic [15:0] iss_wdata[$];
  int          iss_cyc[$];
  logic [2:0]  beat_idx[$];
  logic [15:0] beat_data[$];
  logic        beat_own[$];
  int          beat_cyc[$];
  logic        done_own[$];
  int          done_cyc[$];
  int          ack_cyc[$];
  int          busy_cnt = 0;
  int          wdata_bad = 0;
  int          both_bad = 0;

  always @(negedge clk) begin
    if (mem_en) begin
      iss_addr.push_back(mem_addr);
      iss_wr.push_back(mem_wr);
      iss_wdata.push_back(mem_wdata);
      iss_cyc.push_back(cyc);
      if (!mem_wr && mem_wdata != 16'h0) wdata_bad++;
    end
    if (fill_i_valid || fill_d_valid) begin
      beat_idx.push_back(fill_idx);
      beat_data.push_back(fill_data);
      beat_own.push_back(fill_d_valid);
      beat_cyc.push_back(cyc);
      if (fill_i_valid && fill_d_valid) both_bad++;
    end
    if (i_done || d_done) begin
      done_own.push_back(d_done);
      done_cyc.push_back(cyc);
      if (i_done && d_done) both_bad++;
    end
    if (d_wr_ack) ack_cyc.push_back(cyc);
    if (busy) busy_cnt++;
  end

  // Drop each request when its completion is seen; optionally poke an rvalid into DONE.
  task automatic serve(input int budget, input bit inj_at_done);
    int n = 0;
    while ((d_wr || d_miss || i_miss || busy) && n < budget) begin
      @(negedge clk); #1;
      n++;
      if ((i_done || d_done) && inj_at_done) begin
        inj_data = 16'h5A5A;
        inj_rv   = 1'b1;
        #1;
        check("rv_in_done", {fill_i_valid, fill_d_valid}, 2'b00);
        inj_rv   = 1'b0;
      end
      if (d_wr_ack) d_wr = 1'b0;
      if (d_done)   d_miss = 1'b0;
      if (i_done)   i_miss = 1'b0;
    end
    check("serve_in_budget", n < budget, 1'b1);
  endtask

  task automatic check_fill(input int b, input bit own_d, input logic [15:0] base);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("beat%0d_idx", k), beat_idx[b+k], k);
      check($sformatf("beat%0d_data", k), beat_data[b+k], base + k);
      check($sformatf("beat%0d_own", k), beat_own[b+k], own_d);
    end
  endtask

  task automatic check_reads(input int i0, input logic [15:0] blk);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rd%0d_addr", k), iss_addr[i0+k], blk + 16'(2 * k));
      check($sformatf("rd%0d_wr", k), iss_wr[i0+k], 1'b0);
      check($sformatf("rd%0d_cyc", k), iss_cyc[i0+k] - iss_cyc[i0], k);
    end
  endtask

  int req_cyc, b0, i0, d0, a0, bz0, n;

  initial begin
    rst_n = 1'b0;
    i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", 64'(all_outs), 64'h0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_reset_outs", 64'(all_outs), 64'h0);

    // I-cache fill from 0x1234.
    mem_base = 16'hA000;
    b0 = beat_idx.size(); i0 = iss_addr.size(); d0 = done_own.size(); bz0 = busy_cnt;
    i_miss = 1'b1; i_addr = 16'h1234;
    req_cyc = cyc;
    serve(100, 1'b1);
    check("t1_reads", iss_addr.size() - i0, 8);
    check("t1_first_issue", iss_cyc[i0] - req_cyc, 1);
    check_reads(i0, 16'h1230);
    check("t1_beats", beat_idx.size() - b0, 8);
    check_fill(b0, 1'b0, 16'hA000);
    check("t1_dones", done_own.size() - d0, 1);
    check("t1_done_own", done_own[d0], 1'b0);
    check("t1_done_after_beat7", done_cyc[d0] - beat_cyc[b0+7], 1);
    check("t1_done_cyc", done_cyc[d0] - req_cyc, 13);
    check("t1_busy_cycles", busy_cnt - bz0, 13);

    // Store, D miss and I miss all in the same cycle.
    mem_base = 16'hC000;
    b0 = beat_idx.size(); i0 = iss_addr.size(); d0 = done_own.size(); a0 = ack_cyc.size();
    d_wr = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    d_miss = 1'b1; d_addr = 16'h2208;
    i_miss = 1'b1; i_addr = 16'h3000;
    req_cyc = cyc;
    serve(200, 1'b0);
    check("t2_issues", iss_addr.size() - i0, 17);
    check("t2_wr", iss_wr[i0], 1'b1);
    check("t2_wr_addr", iss_addr[i0], 16'h0040);
    check("t2_wr_data", iss_wdata[i0], 16'hBEEF);
    check("t2_wr_cyc", iss_cyc[i0] - req_cyc, 1);
    check("t2_acks", ack_cyc.size() - a0, 1);
    check("t2_ack_cyc", ack_cyc[a0] - req_cyc, 1);
    check("t2_d_first_issue", iss_cyc[i0+1] - req_cyc, 3);
    check_reads(i0 + 1, 16'h2200);
    check_reads(i0 + 9, 16'h3000);
    check("t2_beats", beat_idx.size() - b0, 16);
    check_fill(b0, 1'b1, 16'hC000);
    check_fill(b0 + 8, 1'b0, 16'hC000);
    check("t2_dones", done_own.size() - d0, 2);
    check("t2_done0_d", done_own[d0], 1'b1);
    check("t2_done1_i", done_own[d0+1], 1'b0);
    check("t2_b2b_issue", iss_cyc[i0+9] - done_cyc[d0], 2);

    // Both misses held together: arbitration order.
    mem_base = 16'h1000;
    b0 = beat_idx.size(); d0 = done_own.size();
    d_miss = 1'b1; d_addr = 16'h0100;
    i_miss = 1'b1; i_addr = 16'h0200;
    n = 0;
    while ((d_miss || i_miss || busy) && n < 400) begin
      @(negedge clk); #1;
      n++;
`ifdef ARB_RR_EN
      if (done_own.size() - d0 >= 4) begin
        d_miss = 1'b0;
        i_miss = 1'b0;
      end
`else
      if (done_own.size() - d0 >= 2) d_miss = 1'b0;
      if (done_own.size() - d0 >= 3) i_miss = 1'b0;
`endif
    end
    check("t3_in_budget", n < 400, 1'b1);
`ifdef ARB_RR_EN
    check("t3_dones", done_own.size() - d0, 4);
    check("t3_order", {done_own[d0], done_own[d0+1], done_own[d0+2], done_own[d0+3]}, 4'b1010);
    for (int f = 0; f < 4; f++) check_fill(b0 + 8 * f, done_own[d0+f], 16'h1000);
`else
    check("t3_dones", done_own.size() - d0, 3);
    check("t3_order", {done_own[d0], done_own[d0+1], done_own[d0+2]}, 3'b110);
    for (int f = 0; f < 3; f++) check_fill(b0 + 8 * f, done_own[d0+f], 16'h1000);
`endif

    // Spurious rvalid while idle.
    b0 = beat_idx.size();
    @(negedge clk); #1;
    inj_data = 16'hDEAD;
    inj_rv   = 1'b1;
    #1;
    check("t4_no_valid", {fill_i_valid, fill_d_valid}, 2'b00);
    check("t4_fill_data", fill_data, 16'h0);
    @(negedge clk); #1;
    check("t4_idle", busy, 1'b0);
    inj_rv = 1'b0;
    check("t4_no_beats", beat_idx.size() - b0, 0);

    // Reset after 3 words of a D fill.
    mem_base = 16'h3300;
    b0 = beat_idx.size();
    d_miss = 1'b1; d_addr = 16'h4400;
    n = 0;
    while (beat_idx.size() - b0 < 3 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check("t5_three_beats", beat_idx.size() - b0, 3);
    rst_n  = 1'b0;
    d_miss = 1'b0;
    #1;
    check("t5_async_outs", 64'(all_outs), 64'h0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    b0 = beat_idx.size();
    repeat (10) @(negedge clk);
    #1;
    check("t5_stale_drained", pend_rdy.size(), 0);
    check("t5_no_stale_beats", beat_idx.size() - b0, 0);
    check("t5_idle", busy, 1'b0);
    mem_base = 16'h5000;
    i0 = iss_addr.size(); d0 = done_own.size();
    d_miss = 1'b1;
    serve(100, 1'b0);
    check_reads(i0, 16'h4400);
    check("t5_beats", beat_idx.size() - b0, 8);
    check_fill(b0, 1'b1, 16'h5000);
    check("t5_done_d", done_own[d0], 1'b1);

    // Variable gaps between returned words.
    gap_mode = 1'b1;
    mem_base = 16'h7000;
    b0 = beat_idx.size(); d0 = done_own.size();
    d_miss = 1'b1; d_addr = 16'h6000;
    serve(300, 1'b0);
    gap_mode = 1'b0;
    check("t6_beats", beat_idx.size() - b0, 8);
    check_fill(b0, 1'b1, 16'h7000);
    check("t6_dones", done_own.size() - d0, 1);
    check("t6_done_after_last", done_cyc[d0] - beat_cyc[b0+7], 1);

    check("wdata_zero_on_reads", wdata_bad, 0);
    check("exclusive_valids", both_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
